// File: rtl/pll_sup_pkg.sv
// Shared definitions for the PLL lock supervisor: state encoding and
// elaboration-time sizing helpers.
package pll_sup_pkg;

    // State encoding is also exported on the STATE debug port.
    typedef enum logic [2:0] {
        ST_PLL_RST   = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAIL      = 3'd4
    } pll_state_t;

    // Number of bits needed to hold the values 0..value-1.
    // clog2(1) = 0, clog2(2) = 1, clog2(4096) = 12.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        m = (m > c) ? m : c;
        return m;
    endfunction

    // Width of a counter holding 0..max_value, never narrower than one bit.
    function automatic int count_width(input int max_value);
        int w;
        w = clog2(max_value + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchroniser for a single asynchronous level input.
// Both flops clear to 0 on reset so an unsynchronised LOCK is never
// reported as locked straight out of reset.
module sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_reg;
    logic sync_reg;

    // First flop may go metastable; second flop gives it a cycle to settle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_reg <= 1'b0;
            sync_reg <= 1'b0;
        end else begin
            meta_reg <= d;
            sync_reg <= meta_reg;
        end
    end

    assign q = sync_reg;

endmodule

// File: rtl/pll_lock_supervisor.sv
// Reset/lock sequencer for one or more PLLs feeding the recorder core.
// Holds the PLLs in reset, waits for every LOCK to assert, requires the
// lock to stay up for a stability window, then releases the core reset.
// Lock timeouts retry the PLL reset a bounded number of times before
// latching FAIL; lock loss while running restarts the whole sequence.
module pll_lock_supervisor
    import pll_sup_pkg::*;
#(
    parameter int NUM_PLL      = 1,
    parameter int RESET_CYCLES = 64,
    parameter int LOCK_STABLE  = 256,
    parameter int LOCK_TIMEOUT = 4096,
    parameter int MAX_RETRIES  = 3,
    parameter int CNT_W        = 8
) (
    input  logic                                REFERENCECLK,
    input  logic                                RESET,
    input  logic [NUM_PLL-1:0]                  LOCK_IN,
    input  logic                                RELOCK_REQ,
    output logic                                PLL_RESETB,
    output logic                                CORE_RESET,
    output logic                                LOCKED,
    output logic                                FAIL,
    output logic [count_width(MAX_RETRIES)-1:0] RETRY_COUNT,
    output logic [CNT_W-1:0]                    LOSS_COUNT,
    output logic [2:0]                          STATE
);

    localparam int TIMER_MAX = max3(RESET_CYCLES, LOCK_STABLE, LOCK_TIMEOUT);
    localparam int TIMER_W   = (clog2(TIMER_MAX) < 1) ? 1 : clog2(TIMER_MAX);
    localparam int RETRY_W   = count_width(MAX_RETRIES);

    // Terminal timer values: the timer starts at 0 on entry to a state,
    // so an N-cycle interval ends when the timer reads N-1.
    localparam logic [TIMER_W-1:0] RESET_LAST   = TIMER_W'(RESET_CYCLES - 1);
    localparam logic [TIMER_W-1:0] STABLE_LAST  = TIMER_W'(LOCK_STABLE - 1);
    localparam logic [TIMER_W-1:0] TIMEOUT_LAST = TIMER_W'(LOCK_TIMEOUT - 1);
    localparam logic [RETRY_W-1:0] RETRY_LIMIT  = RETRY_W'(MAX_RETRIES);
    localparam logic [CNT_W-1:0]   LOSS_SAT     = {CNT_W{1'b1}};

    // ------------------------------------------------------------------
    // LOCK synchronisation: one synchroniser per PLL, all must be locked.
    // ------------------------------------------------------------------
    logic [NUM_PLL-1:0] lock_sync;
    logic               lock_all;

    for (genvar gi = 0; gi < NUM_PLL; gi++) begin : g_lock_sync
        sync2 u_sync2 (
            .clk (REFERENCECLK),
            .rst (RESET),
            .d   (LOCK_IN[gi]),
            .q   (lock_sync[gi])
        );
    end

    assign lock_all = &lock_sync;

    // ------------------------------------------------------------------
    // Sequencer state, interval timer and status counters.
    // ------------------------------------------------------------------
    pll_state_t         state_reg,  state_next;
    logic [TIMER_W-1:0] timer_reg,  timer_next;
    logic [RETRY_W-1:0] retry_reg,  retry_next;
    logic [CNT_W-1:0]   loss_reg,   loss_next;

    // Outputs are registered decodes of the next state so that they move
    // on exactly the same edge as STATE and never glitch.
    logic pll_resetb_reg, pll_resetb_next;
    logic core_reset_reg, core_reset_next;
    logic locked_reg,     locked_next;
    logic fail_reg,       fail_next;

    // Next-state, timer and counter update, followed by output decode.
    always_comb begin
        state_next = state_reg;
        timer_next = timer_reg;
        retry_next = retry_reg;
        loss_next  = loss_reg;

        if (RELOCK_REQ) begin
            // A relock request overrides everything, including a lock drop
            // seen in the same cycle, so it is never counted as a loss.
            state_next = ST_PLL_RST;
            timer_next = '0;
            retry_next = '0;
        end else begin
            unique case (state_reg)
                ST_PLL_RST: begin
                    if (timer_reg == RESET_LAST) begin
                        state_next = ST_WAIT_LOCK;
                        timer_next = '0;
                    end else begin
                        timer_next = timer_reg + TIMER_W'(1);
                    end
                end

                ST_WAIT_LOCK: begin
                    // Lock is tested first so a lock arriving on the timeout
                    // cycle is accepted rather than triggering a retry.
                    if (lock_all) begin
                        state_next = ST_STABLE;
                        timer_next = '0;
                    end else if (timer_reg == TIMEOUT_LAST) begin
                        timer_next = '0;
                        if (retry_reg == RETRY_LIMIT) begin
                            state_next = ST_FAIL;
                        end else begin
                            state_next = ST_PLL_RST;
                            retry_next = retry_reg + RETRY_W'(1);
                        end
                    end else begin
                        timer_next = timer_reg + TIMER_W'(1);
                    end
                end

                ST_STABLE: begin
                    // A glitch only restarts the wait; the PLL keeps running
                    // and the attempt is not counted as a retry.
                    if (!lock_all) begin
                        state_next = ST_WAIT_LOCK;
                        timer_next = '0;
                    end else if (timer_reg == STABLE_LAST) begin
                        state_next = ST_RUN;
                        timer_next = '0;
                        retry_next = '0;
                    end else begin
                        timer_next = timer_reg + TIMER_W'(1);
                    end
                end

                ST_RUN: begin
                    retry_next = '0;
                    timer_next = '0;
                    if (!lock_all) begin
                        state_next = ST_PLL_RST;
                        if (loss_reg != LOSS_SAT) begin
                            loss_next = loss_reg + CNT_W'(1);
                        end
                    end
                end

                ST_FAIL: begin
                    timer_next = '0;
                end

                default: begin
                    state_next = ST_PLL_RST;
                    timer_next = '0;
                    retry_next = '0;
                end
            endcase
        end

        pll_resetb_next = (state_next == ST_WAIT_LOCK) ||
                          (state_next == ST_STABLE)    ||
                          (state_next == ST_RUN);
        core_reset_next = (state_next != ST_RUN);
        locked_next     = (state_next == ST_RUN);
        fail_next       = (state_next == ST_FAIL);
    end

    // State, counters and decoded outputs; RESET returns everything to the
    // start of a fresh PLL reset immediately, without waiting for a clock.
    always_ff @(posedge REFERENCECLK or posedge RESET) begin
        if (RESET) begin
            state_reg      <= ST_PLL_RST;
            timer_reg      <= '0;
            retry_reg      <= '0;
            loss_reg       <= '0;
            pll_resetb_reg <= 1'b0;
            core_reset_reg <= 1'b1;
            locked_reg     <= 1'b0;
            fail_reg       <= 1'b0;
        end else begin
            state_reg      <= state_next;
            timer_reg      <= timer_next;
            retry_reg      <= retry_next;
            loss_reg       <= loss_next;
            pll_resetb_reg <= pll_resetb_next;
            core_reset_reg <= core_reset_next;
            locked_reg     <= locked_next;
            fail_reg       <= fail_next;
        end
    end

    assign PLL_RESETB  = pll_resetb_reg;
    assign CORE_RESET  = core_reset_reg;
    assign LOCKED      = locked_reg;
    assign FAIL        = fail_reg;
    assign RETRY_COUNT = retry_reg;
    assign LOSS_COUNT  = loss_reg;
    assign STATE       = state_reg;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Scoreboard bench for pll_lock_supervisor. A behavioural model counts
// cycles spent in each phase and sees LOCK_IN two edges late; every stimulus
// cycle pushes the expected outputs, and a monitor pops and compares them.
module tb_pll_lock_supervisor;

    localparam int NP = 2;
    localparam int RC = 4;
    localparam int LS = 8;
    localparam int LT = 16;
    localparam int MR = 2;
    localparam int CW = 2;

    localparam int P_RST  = 0;
    localparam int P_WAIT = 1;
    localparam int P_STAB = 2;
    localparam int P_RUN  = 3;
    localparam int P_FAIL = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [NP-1:0] lock_in;
    logic          relock;
    logic          pll_resetb;
    logic          core_reset;
    logic          locked;
    logic          fail;
    logic [1:0]    retry_count;
    logic [CW-1:0] loss_count;
    logic [2:0]    state;

    always #5 clk = ~clk;

    pll_lock_supervisor #(
        .NUM_PLL      (NP),
        .RESET_CYCLES (RC),
        .LOCK_STABLE  (LS),
        .LOCK_TIMEOUT (LT),
        .MAX_RETRIES  (MR),
        .CNT_W        (CW)
    ) dut (
        .REFERENCECLK (clk),
        .RESET        (rst),
        .LOCK_IN      (lock_in),
        .RELOCK_REQ   (relock),
        .PLL_RESETB   (pll_resetb),
        .CORE_RESET   (core_reset),
        .LOCKED       (locked),
        .FAIL         (fail),
        .RETRY_COUNT  (retry_count),
        .LOSS_COUNT   (loss_count),
        .STATE        (state)
    );

    typedef struct packed {
        logic [2:0]    st;
        logic          resetb;
        logic          core_rst;
        logic          lkd;
        logic          fl;
        logic [1:0]    retry;
        logic [CW-1:0] loss;
    } exp_t;

    exp_t exp_q[$];
    int   vectors     = 0;
    int   miscompares = 0;

    // Behavioural model state.
    int            m_phase;
    int            m_age;
    int            m_retry;
    int            m_loss;
    logic [NP-1:0] d1;
    logic [NP-1:0] d2;

    function automatic exp_t model_outputs();
        exp_t e;
        e.st       = 3'(m_phase);
        e.resetb   = (m_phase == P_WAIT) || (m_phase == P_STAB) || (m_phase == P_RUN);
        e.core_rst = (m_phase != P_RUN);
        e.lkd      = (m_phase == P_RUN);
        e.fl       = (m_phase == P_FAIL);
        e.retry    = 2'(m_retry);
        e.loss     = CW'(m_loss);
        return e;
    endfunction

    task automatic model_reset();
        m_phase = P_RST;
        m_age   = 0;
        m_retry = 0;
        m_loss  = 0;
        d1      = '0;
        d2      = '0;
    endtask

    // One clock edge of the reference behaviour. The lock seen on an edge is
    // the LOCK_IN value applied two edges earlier.
    task automatic model_edge(input logic [NP-1:0] li, input logic rq);
        logic lk;
        lk = (d2 == {NP{1'b1}});
        d2 = d1;
        d1 = li;
        if (rq) begin
            m_phase = P_RST;
            m_age   = 0;
            m_retry = 0;
        end else begin
            case (m_phase)
                P_RST: begin
                    m_age++;
                    if (m_age == RC) begin
                        m_phase = P_WAIT;
                        m_age   = 0;
                    end
                end
                P_WAIT: begin
                    if (lk) begin
                        m_phase = P_STAB;
                        m_age   = 0;
                    end else begin
                        m_age++;
                        if (m_age == LT) begin
                            m_age = 0;
                            if (m_retry == MR) begin
                                m_phase = P_FAIL;
                            end else begin
                                m_retry++;
                                m_phase = P_RST;
                            end
                        end
                    end
                end
                P_STAB: begin
                    if (!lk) begin
                        m_phase = P_WAIT;
                        m_age   = 0;
                    end else begin
                        m_age++;
                        if (m_age == LS) begin
                            m_phase = P_RUN;
                            m_age   = 0;
                            m_retry = 0;
                        end
                    end
                end
                P_RUN: begin
                    if (!lk) begin
                        if (m_loss < (1 << CW) - 1) m_loss++;
                        m_phase = P_RST;
                        m_age   = 0;
                    end
                end
                default: ;
            endcase
        end
    endtask

    task automatic check(input exp_t e, input string name);
        exp_t a;
        a = {state, pll_resetb, core_reset, locked, fail, retry_count, loss_count};
        vectors++;
        if (a !== e) begin
            miscompares++;
            $display("FAIL %s @%0t: got st=%0d rb=%0b cr=%0b lk=%0b fl=%0b rt=%0d ls=%0d, expected st=%0d rb=%0b cr=%0b lk=%0b fl=%0b rt=%0d ls=%0d",
                     name, $time, a.st, a.resetb, a.core_rst, a.lkd, a.fl, a.retry, a.loss,
                     e.st, e.resetb, e.core_rst, e.lkd, e.fl, e.retry, e.loss);
        end
    endtask

    // Apply one cycle of stimulus and record what the next edge should produce.
    task automatic step(input logic [NP-1:0] li, input logic rq);
        @(negedge clk);
        rst     = 1'b0;
        lock_in = li;
        relock  = rq;
        model_edge(li, rq);
        exp_q.push_back(model_outputs());
        $display("vec t=%0t lock_in=%b relock=%0b -> exp st=%0d", $time, li, rq, m_phase);
    endtask

    // Assert RESET between edges and confirm the outputs clear without a clock.
    task automatic do_reset();
        exp_t e;
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        model_reset();
        e = model_outputs();
        check(e, "async_reset");
        @(posedge clk);
        @(posedge clk);
    endtask

    // Step until the chosen output goes high, then compare the cycle count.
    task automatic wait_for(input int sel, input logic [NP-1:0] li, input int budget,
                            input int want, input string name);
        int   n;
        logic seen;
        n    = 0;
        seen = 1'b0;
        while (!seen && n < budget) begin
            step(li, 1'b0);
            @(posedge clk);
            #2;
            n++;
            case (sel)
                0:       seen = locked;
                1:       seen = fail;
                default: seen = core_reset;
            endcase
        end
        vectors++;
        $display("txn %s: after %0d cycles (seen=%0b), want %0d", name, n, seen, want);
        if (!seen || n != want) begin
            miscompares++;
            $display("FAIL %s: reached after %0d cycles (seen=%0b), required %0d", name, n, seen, want);
        end
    endtask

    // Monitor: one expected record per edge while stimulus is running.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check(e, "cycle");
            end
        end
    end

    initial begin
        logic [NP-1:0] val;
        int            hold;
        rst     = 1'b1;
        lock_in = '0;
        relock  = 1'b0;
        model_reset();

        // Nominal lock.
        do_reset();
        wait_for(0, 2'b11, 40, 13, "nominal_locked");
        repeat (4) step(2'b11, 1'b0);

        // Total timeout: three PLL resets then FAIL.
        do_reset();
        wait_for(1, 2'b00, 100, 60, "timeout_fail");
        repeat (6) step(2'b00, 1'b0);

        // Partial lock, then relock with both PLLs locked.
        do_reset();
        wait_for(1, 2'b01, 100, 60, "partial_fail");
        step(2'b11, 1'b1);
        wait_for(0, 2'b11, 40, 13, "relock_locked");

        // One-cycle glitch on LOCK_IN[1] during the stability window.
        do_reset();
        repeat (8) step(2'b11, 1'b0);
        step(2'b01, 1'b0);
        wait_for(0, 2'b11, 40, 11, "glitch_locked");

        // Five losses in RUN with a 2-bit saturating loss counter.
        for (int i = 0; i < 5; i++) begin
            step((i % 2 == 0) ? 2'b10 : 2'b00, 1'b0);
            wait_for(2, 2'b11, 10, 2, "loss_core_reset");
            wait_for(0, 2'b11, 40, 13, "loss_relocked");
        end
        vectors++;
        if (loss_count !== 2'd3) begin
            miscompares++;
            $display("FAIL loss_saturate: got %0d, required 3", loss_count);
        end

        // Relock in the same cycle the lock drop reaches the FSM.
        step(2'b00, 1'b0);
        step(2'b00, 1'b0);
        step(2'b00, 1'b1);
        repeat (20) step(2'b11, 1'b0);

        // Asynchronous reset while in the stability window.
        do_reset();
        repeat (8) step(2'b11, 1'b0);
        do_reset();
        wait_for(0, 2'b11, 40, 13, "post_reset_locked");

        // Randomised run-length lock patterns with occasional relock pulses.
        do_reset();
        for (int i = 0; i < 1500; i += hold) begin
            hold = $urandom_range(1, 25);
            val  = ($urandom_range(0, 9) < 6) ? 2'b11 : 2'($urandom_range(0, 3));
            for (int k = 0; k < hold; k++) begin
                step(val, ($urandom_range(0, 99) < 2) ? 1'b1 : 1'b0);
            end
        end

        // Let the monitor drain, bounded.
        repeat (3) @(posedge clk);
        #3;
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expected records left, required 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
